ysyx_25060170_lsu: RTL
======================

# ysyx_25060170_lsu

Load/store unit between EXU and WBU in the NPC pipeline. It takes the ALU result (effective address or plain result) plus memory-op controls from EXU, and runs at most one outstanding access on a request/grant/response data-memory port. It returns a 32-bit writeback value to WBU with a valid/ready handshake. Non-memory instructions pass the ALU result through with one cycle of latency.

## Interface
- TIMEOUT_CYC, 255: maximum WAIT cycles before `lsu_err_o` is raised; 0 disables the timeout.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- lsu_valid_i  in  1  EXU result valid (driven from `exu_ready_o`).
- lsu_ready_o  out  1  LSU can accept. Equals (state==IDLE) & ~rst.
- lsu_addr_i  in  32  ALU result (`exu_res1`); used as the address for memory ops.
- lsu_wdata_i  in  32  store data (rs2).
- lsu_mem_en_i  in  1  instruction is a load or store.
- lsu_wen_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- lsu_unsigned_i  in  1  zero-extend load result (lbu/lhu).
- mem_req_o  out  1  memory request; held until granted.
- mem_we_o  out  1  write request.
- mem_addr_o  out  32  word-aligned address, {addr[31:2], 2'b00}.
- mem_wdata_o  out  32  store data, replicated into byte lanes.
- mem_wmask_o  out  4  byte-lane write enables.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  response (read data or write ack); arrives no earlier than the cycle after grant.
- mem_rdata_i  in  32  read data; valid with `mem_rvalid_i`.
- lsu_valid_o  out  1  writeback result valid.
- lsu_ready_i  in  1  WBU accepts.
- lsu_res_o  out  32  writeback value.
- lsu_misalign_o  out  1  misaligned access flag; qualified by `lsu_valid_o`.
- lsu_err_o  out  1  memory timeout flag; qualified by `lsu_valid_o`.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE: on lsu_valid_i & lsu_ready_o, register all inputs.
  - Not a memory op: go to RESP with res = addr.
  - Memory op: go to REQ, or to RESP on a misalignment when checking is compiled in.
- REQ: hold mem_req_o=1 with stable address, data and mask. On mem_gnt_i go to WAIT and clear the timeout counter.
- WAIT: mem_req_o=0.
  - On mem_rvalid_i go to RESP. For loads, res = extended data; for stores, res = 0.
  - Otherwise increment the counter. When counter == TIMEOUT_CYC-1 (only if TIMEOUT_CYC≠0), go to RESP with lsu_err_o=1 and res=0.
- RESP: lsu_valid_o=1 with stable outputs. On lsu_ready_i go to IDLE.
- Write lanes:
  - sb: wmask = 4'b0001<<addr[1:0], wdata = {4{b}}.
  - sh: wmask = 4'b0011<<addr[1:0], wdata = {2{h}}.
  - sw: wmask = 4'b1111.
  - mem_wmask_o = 0 for loads.
- Load extract:
  - byte = rdata >> (addr[1:0]*8).
  - half = rdata >> (addr[1]*16).
  - Sign-extend unless lsu_unsigned_i is set.
- Stray mem_rvalid_i in IDLE, REQ or RESP is ignored. This includes a late response after a timeout or reset.
- Reset mid-transaction abandons the access: state goes to IDLE, mem_req_o drops, and lsu_valid_o, lsu_err_o and lsu_misalign_o clear.

## Timing
- Reset values: mem_req_o, mem_we_o, lsu_valid_o, lsu_err_o and lsu_misalign_o are 0. mem_addr_o, mem_wdata_o, mem_wmask_o and lsu_res_o are 0. lsu_ready_o is 0 during rst and 1 in the cycle after.
- Non-memory op: accepted at edge E0, lsu_valid_o high from E0 onward (latency 1).
- Memory op with immediate grant and rvalid the next cycle: req in cycle 1, WAIT in cycle 2, valid in cycle 3 (latency 3).
- Grant stalls add one cycle each. WBU backpressure holds RESP indefinitely with outputs stable.
- No new accept while state≠IDLE; the throughput bound is one instruction per 2 cycles for non-memory ops.

## Configuration
- YSYX_25060170_LSU_MISALIGN_CHK_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, issues no memory request.
  - The access goes straight to RESP with lsu_misalign_o=1 and res = addr (one-cycle latency).
- Macro undefined:
  - Offending low address bits are masked (half: bit0 forced 0; word: bits[1:0] forced 0).
  - lsu_misalign_o is tied 0.

## Structure
- Shared package/header ysyx_25060170_pkg holds:
  - LSU_SZ_B/H/W size codes
  - LSU_IDLE/REQ/WAIT/RESP state encodings
  - the 32-bit data-width constant
- Sub-module ysyx_25060170_lsu_align: combinational wmask/wdata generation and load extraction/extension. The FSM, registers and timeout counter stay in the top module.

## Test plan
- ALU op, addr=0x1234_5678, lsu_ready_i=1 -> lsu_valid_o one cycle later with res=0x1234_5678; no mem_req_o.
- lb at addr=0x8000_0003, rdata=0x80AA_BBCC -> mem_addr_o=0x8000_0000, res=0xFFFF_FF80; lbu at the same address -> res=0x0000_0080.
- sh addr=0x8000_0002, wdata=0x0000_BEEF -> wmask=4'b1100, mem_wdata_o=0xBEEF_BEEF, mem_we_o=1; after rvalid, res=0.
- gnt delayed 3 cycles, and lsu_ready_i low for 2 cycles in RESP -> mem_req_o held with stable address; lsu_res_o stable; exactly one memory access.
- TIMEOUT_CYC=4, no rvalid -> lsu_err_o=1 and res=0 after 4 WAIT cycles; a later stray rvalid is ignored. rst asserted in WAIT -> IDLE next cycle, and lsu_ready_o=1 after rst drops.
- With the macro defined: lw addr=0x8000_0002 -> no mem_req_o, lsu_misalign_o=1, res=0x8000_0002. With the macro undefined: mem_addr_o=0x8000_0000.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared LSU definitions: size codes, FSM state encodings, data width and
// the misalignment predicate used when YSYX_25060170_LSU_MISALIGN_CHK_EN is set.
package ysyx_25060170_pkg;

    localparam int unsigned LSU_DW = 32'd32;

    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // Size code 3 is reserved and behaves like a word access.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            LSU_SZ_B: mis = 1'b0;
            LSU_SZ_H: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25060170_lsu_if.sv
// Data-memory request/grant/response port between the LSU (master) and memory (slave).
interface ysyx_25060170_lsu_if;
    import ysyx_25060170_pkg::*;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [LSU_DW-1:0] mem_addr_o;
    logic [LSU_DW-1:0] mem_wdata_o;
    logic [3:0]        mem_wmask_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [LSU_DW-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/ysyx_25060170_lsu_align.sv
// Byte-lane steering: store mask/data replication and load extraction with
// sign or zero extension. Purely combinational.
module ysyx_25060170_lsu_align
    import ysyx_25060170_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_off,
    input  logic [LSU_DW-1:0] st_data,
    output logic [3:0]        st_wmask,
    output logic [LSU_DW-1:0] st_wdata,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_off,
    input  logic              ld_unsigned,
    input  logic [LSU_DW-1:0] ld_rdata,
    output logic [LSU_DW-1:0] ld_data
);

    logic [LSU_DW-1:0] byte_shift_s;
    logic [LSU_DW-1:0] half_shift_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;

    // Store side: lane enables follow the low address bits, data is replicated.
    always_comb begin
        st_wmask = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            LSU_SZ_B: begin
                st_wmask = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            LSU_SZ_H: begin
                st_wmask = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_wmask = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load side: shift the addressed lane down, then extend to 32 bits.
    always_comb begin
        byte_shift_s = ld_rdata >> {ld_off, 3'b000};
        half_shift_s = ld_rdata >> {ld_off[1], 4'b0000};
        byte_s       = byte_shift_s[7:0];
        half_s       = half_shift_s[15:0];
        ld_data      = ld_rdata;
        case (ld_size)
            LSU_SZ_B: begin
                if (ld_unsigned) begin
                    ld_data = {24'd0, byte_s};
                end else begin
                    ld_data = {{24{byte_s[7]}}, byte_s};
                end
            end
            LSU_SZ_H: begin
                if (ld_unsigned) begin
                    ld_data = {16'd0, half_s};
                end else begin
                    ld_data = {{16{half_s[15]}}, half_s};
                end
            end
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: one outstanding data-memory access, 32-bit writeback to WBU.
// Build option: YSYX_25060170_LSU_MISALIGN_CHK_EN flags misaligned half/word accesses.
module ysyx_25060170_lsu
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [LSU_DW-1:0] lsu_addr_i,
    input  logic [LSU_DW-1:0] lsu_wdata_i,
    input  logic              lsu_mem_en_i,
    input  logic              lsu_wen_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_unsigned_i,
    output logic              lsu_valid_o,
    input  logic              lsu_ready_i,
    output logic [LSU_DW-1:0] lsu_res_o,
    output logic              lsu_misalign_o,
    output logic              lsu_err_o,
    ysyx_25060170_lsu_if.master mem
);

    lsu_state_e        state_r, state_s;
    logic [LSU_DW-1:0] addr_r, addr_s;
    logic [LSU_DW-1:0] wdata_r, wdata_s;
    logic [3:0]        wmask_r, wmask_s;
    logic              we_r, we_s;
    logic [1:0]        size_r, size_s;
    logic              uns_r, uns_s;
    logic [LSU_DW-1:0] res_r, res_s;
    logic              err_r, err_s;
    logic              mis_r, mis_s;
    logic              req_r, req_s;
    logic              valid_r, valid_s;
    logic [31:0]       cnt_r, cnt_s;

    logic              ready_s;
    logic              accept_s;
    logic              mis_chk_s;
    logic [LSU_DW-1:0] eff_addr_s;
    logic [3:0]        st_wmask_s;
    logic [LSU_DW-1:0] st_wdata_s;
    logic [LSU_DW-1:0] ld_data_s;

    assign ready_s  = (state_r == LSU_IDLE) & ~rst;
    assign accept_s = lsu_valid_i & ready_s;

    // Effective address: offending low bits are dropped for half/word accesses.
    always_comb begin
        eff_addr_s = lsu_addr_i;
        case (lsu_size_i)
            LSU_SZ_B: eff_addr_s = lsu_addr_i;
            LSU_SZ_H: eff_addr_s = {lsu_addr_i[31:1], 1'b0};
            default:  eff_addr_s = {lsu_addr_i[31:2], 2'b00};
        endcase
    end

`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    assign mis_chk_s = lsu_mem_en_i & lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
    assign mis_chk_s = 1'b0;
`endif

    ysyx_25060170_lsu_align u_align (
        .st_size     (lsu_size_i),
        .st_off      (eff_addr_s[1:0]),
        .st_data     (lsu_wdata_i),
        .st_wmask    (st_wmask_s),
        .st_wdata    (st_wdata_s),
        .ld_size     (size_r),
        .ld_off      (addr_r[1:0]),
        .ld_unsigned (uns_r),
        .ld_rdata    (mem.mem_rdata_i),
        .ld_data     (ld_data_s)
    );

    // Next-state and next-value logic; every register holds unless updated here.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        wmask_s = wmask_r;
        we_s    = we_r;
        size_s  = size_r;
        uns_s   = uns_r;
        res_s   = res_r;
        err_s   = err_r;
        mis_s   = mis_r;
        cnt_s   = cnt_r;
        case (state_r)
            LSU_IDLE: begin
                if (accept_s) begin
                    addr_s  = eff_addr_s;
                    wdata_s = st_wdata_s;
                    wmask_s = (lsu_mem_en_i & lsu_wen_i) ? st_wmask_s : 4'b0000;
                    we_s    = lsu_mem_en_i & lsu_wen_i;
                    size_s  = lsu_size_i;
                    uns_s   = lsu_unsigned_i;
                    res_s   = lsu_addr_i;
                    err_s   = 1'b0;
                    mis_s   = mis_chk_s;
                    cnt_s   = 32'd0;
                    if (~lsu_mem_en_i | mis_chk_s) begin
                        state_s = LSU_RESP;
                    end else begin
                        state_s = LSU_REQ;
                    end
                end else begin
                    state_s = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                if (mem.mem_gnt_i) begin
                    state_s = LSU_WAIT;
                    cnt_s   = 32'd0;
                end else begin
                    state_s = LSU_REQ;
                end
            end
            LSU_WAIT: begin
                if (mem.mem_rvalid_i) begin
                    state_s = LSU_RESP;
                    res_s   = we_r ? 32'd0 : ld_data_s;
                end else if ((TIMEOUT_CYC != 32'd0) && (cnt_r == TIMEOUT_CYC - 32'd1)) begin
                    state_s = LSU_RESP;
                    err_s   = 1'b1;
                    res_s   = 32'd0;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            LSU_RESP: begin
                if (lsu_ready_i) begin
                    state_s = LSU_IDLE;
                end else begin
                    state_s = LSU_RESP;
                end
            end
            default: state_s = LSU_IDLE;
        endcase
        req_s   = (state_s == LSU_REQ);
        valid_s = (state_s == LSU_RESP);
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LSU_IDLE;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            wmask_r <= 4'b0000;
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
            res_r   <= 32'd0;
            err_r   <= 1'b0;
            mis_r   <= 1'b0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            wmask_r <= wmask_s;
            we_r    <= we_s;
            size_r  <= size_s;
            uns_r   <= uns_s;
            res_r   <= res_s;
            err_r   <= err_s;
            mis_r   <= mis_s;
            req_r   <= req_s;
            valid_r <= valid_s;
            cnt_r   <= cnt_s;
        end
    end

    assign lsu_ready_o     = ready_s;
    assign lsu_valid_o     = valid_r;
    assign lsu_res_o       = res_r;
    assign lsu_err_o       = err_r;
    assign lsu_misalign_o  = mis_r;
    assign mem.mem_req_o   = req_r;
    assign mem.mem_we_o    = we_r;
    assign mem.mem_addr_o  = {addr_r[31:2], 2'b00};
    assign mem.mem_wdata_o = wdata_r;
    assign mem.mem_wmask_o = wmask_r;

endmodule
